lc4_muldiv_seq: RTL
===================

# lc4_muldiv_seq

Multi-cycle sequencer for the LC4 execute stage's MUL, DIV and MOD operations. It takes these three operations off the single-cycle ALU path and iterates them over 16 cycles using a shared shift/add-subtract datapath. While it works, it stalls the pipeline with a combinational stall signal. It sits beside `lc4_alu` in X; the pipeline muxes in `o_result` when `o_done` is high.

## Interface
Parameters:
- `W`, default 16: operand and result width; iteration count equals `W`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `gwe` in 1: global write enable; when 0, all state holds.
- `i_valid` in 1: an instruction is present in X.
- `i_flush` in 1: squash the X instruction (branch mispredict).
- `i_insn` in 16: X-stage instruction.
- `i_r1data` in 16: rs value (multiplicand or dividend).
- `i_r2data` in 16: rt value (multiplier or divisor).
- `o_stall` out 1: combinational; hold F/D/X.
- `o_done` out 1: registered; result valid this cycle.
- `o_result` out 16: registered result.

## Operation
Decode:
- MUL: `insn[15:12]=0001` and `[5:3]=001`.
- DIV: `insn[15:12]=0001` and `[5:3]=011`.
- MOD: `insn[15:12]=1010` and `[5:4]=11`.
- Any other instruction is not an md-op.

Arithmetic:
- All arithmetic is unsigned.
- MUL returns the low 16 bits of the product. It is computed shift-add, LSB-first, one bit per cycle.
- DIV and MOD use restoring division, MSB-first, one bit per cycle. DIV returns the quotient; MOD returns the remainder.
- A divisor of 0 yields a result of 0 for both DIV and MOD.

FSM states are IDLE, BUSY and DONE. All transitions below require `gwe=1`.
- IDLE:
  - Accept when `i_valid & md-op & !i_flush`.
  - On accept: latch operands and the op, clear the accumulators, set `cnt=0`.
  - Go to BUSY. For DIV/MOD with divisor 0, go directly to DONE instead, with result 0.
- BUSY:
  - Perform one iteration per cycle and increment `cnt`.
  - On the cycle `cnt=W-1` completes, register `o_result` and go to DONE.
- DONE:
  - Assert `o_done`.
  - Ignore `i_valid` for one cycle; the same instruction is still presented in X, so this prevents re-acceptance.
  - Go to IDLE.
- Stall equation: `o_stall = (IDLE & i_valid & md-op & !i_flush) | BUSY`. The stall is low in DONE so the pipeline advances.
- Flush: `i_flush` in BUSY or DONE forces IDLE and deasserts `o_done` the next cycle. No result is produced. Flush has priority over every other transition.
- `gwe=0`: state, counter, accumulators and outputs all hold. `o_stall` is still evaluated combinationally from the held state.
- Reset (asynchronous, any state):
  - State goes to IDLE; `cnt`, accumulators and `o_result` go to 0; `o_done` goes to 0.
  - `o_stall=0` while `i_valid=0`.
  - Any in-flight operation is lost.

## Timing
- Nonzero operation: accept in cycle 0 (`o_stall=1`), BUSY in cycles 1..16 (`o_stall=1`), DONE in cycle 17 (`o_done=1`, `o_stall=0`). Latency is 17 cycles; the instruction occupies X for 18 cycles.
- Divide by zero: accept in cycle 0 with stall, DONE in cycle 1.
- Back-to-back md-ops: the next op is accepted no earlier than the cycle after DONE.
- `o_result` holds its last value until the next completion or reset.
- The counter is `$clog2(W)` bits wide. It never wraps in BUSY, because exit happens at `W-1`.

## Structure
- Package `lc4_md_pkg` contains:
  - the state enum (IDLE, BUSY, DONE);
  - the op enum (MUL, DIV, MOD);
  - the opcode and subop constants (`0001/001`, `0001/011`, `1010/11`);
  - `W`.
- Sub-module `lc4_md_step`: one combinational iteration.
  - Inputs: op, accumulator, remainder, operand registers.
  - Outputs: next accumulator and next remainder.
  - The top level holds the FSM, counter and registers.

## Test plan
- MUL `r1=0x0123`, `r2=0x0010` -> `o_stall` high for cycles 0-16; `o_done=1` and `o_result=0x1230` in cycle 17. Also `0xFFFF*0xFFFF` -> `0x0001`.
- DIV then MOD with `r1=100`, `r2=7` -> results 14 and 2, each with 17-cycle latency. Also `0xFFFF/0x0002` -> `0x7FFF` and MOD -> `0x0001`.
- DIV `0x1234/0` -> `o_done=1` and `o_result=0` in cycle 1; MOD with divisor 0 likewise gives 0.
- Flush in cycle 5 of a DIV -> IDLE in cycle 6 with `o_stall=0` and no `o_done`. A new MUL presented in cycle 6 is accepted and completes correctly.
- Reset asserted mid-BUSY, asynchronously between edges -> outputs are 0 immediately and state is IDLE. `gwe=0` for cycles 3-8 of a MUL -> completion slips by 6 cycles and the result is still correct.
- ADD/AND/SLL with `i_valid=1` -> `o_stall` stays 0 and the FSM stays IDLE. In DONE with `i_valid` still high on the same MUL -> no re-accept and `o_stall=0`.

Source files
------------

// File: rtl/lc4_md_pkg.sv
// lc4_md_pkg: shared types and constants for the LC4 multi-cycle MUL/DIV/MOD
// sequencer: FSM state and op enums, opcode/subop encodings, the default
// datapath width, and the instruction decoder used by the sequencer.
package lc4_md_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MUL,
        DIV,
        MOD
    } op_t;

    localparam logic [3:0] OPC_ARITH = 4'b0001;
    localparam logic [2:0] SUB_MUL   = 3'b001;
    localparam logic [2:0] SUB_DIV   = 3'b011;
    localparam logic [3:0] OPC_MOD   = 4'b1010;
    localparam logic [1:0] SUB_MOD   = 2'b11;

    typedef struct packed {
        logic is_md;
        op_t  op;
    } md_dec_t;

    // Classifies an X-stage instruction as one of the three md-ops.
    function automatic md_dec_t decode_md(input logic [15:0] insn);
        md_dec_t d;
        d.is_md = 1'b0;
        d.op    = MUL;
        if (insn[15:12] == OPC_ARITH && insn[5:3] == SUB_MUL) begin
            d.is_md = 1'b1;
            d.op    = MUL;
        end else if (insn[15:12] == OPC_ARITH && insn[5:3] == SUB_DIV) begin
            d.is_md = 1'b1;
            d.op    = DIV;
        end else if (insn[15:12] == OPC_MOD && insn[5:4] == SUB_MOD) begin
            d.is_md = 1'b1;
            d.op    = MOD;
        end
        return d;
    endfunction

endpackage

// File: rtl/lc4_md_step.sv
// lc4_md_step: one combinational iteration of the shared shift/add-subtract
// datapath.
//   op       : MUL, DIV or MOD
//   acc      : product accumulator (MUL) or quotient being built (DIV/MOD)
//   rem      : partial remainder (DIV/MOD)
//   opa      : multiplicand shifted left per step (MUL) or dividend shifted
//              left per step so its MSB is the next bit to bring down (DIV/MOD)
//   opb      : multiplier shifted right per step (MUL) or divisor (DIV/MOD)
//   acc_next : accumulator after this iteration
//   rem_next : remainder after this iteration
module lc4_md_step
    import lc4_md_pkg::*;
#(
    parameter int W = lc4_md_pkg::W
) (
    input  op_t          op,
    input  logic [W-1:0] acc,
    input  logic [W-1:0] rem,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic [W-1:0] acc_next,
    output logic [W-1:0] rem_next
);

    // The shifted remainder can reach 2*divisor-1, so the trial needs W+1 bits.
    logic [W:0] trial;

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves it unassigned would infer a latch.
    always_comb begin
        acc_next = acc;
        rem_next = rem;
        trial    = {rem, opa[W-1]};
        if (op == MUL) begin
            if (opb[0]) begin
                acc_next = acc + opa;
            end
        end else begin
            // Restoring division: keep the subtraction only if it does not borrow.
            if (trial >= {1'b0, opb}) begin
                rem_next = W'(trial - {1'b0, opb});
                acc_next = {acc[W-2:0], 1'b1};
            end else begin
                rem_next = trial[W-1:0];
                acc_next = {acc[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/lc4_muldiv_seq.sv
// lc4_muldiv_seq: multi-cycle sequencer for LC4 MUL, DIV and MOD in the X stage.
// Iterates W cycles over lc4_md_step and stalls F/D/X while it works.
//   clk, rst     : clock, asynchronous active-high reset
//   gwe          : global write enable; 0 freezes all state
//   i_valid      : an instruction is present in X
//   i_flush      : squash the X instruction
//   i_insn       : X-stage instruction
//   i_r1data     : multiplicand / dividend
//   i_r2data     : multiplier / divisor
//   o_stall      : combinational pipeline hold
//   o_done       : registered, result valid this cycle
//   o_result     : registered result, held until the next completion
module lc4_muldiv_seq
    import lc4_md_pkg::*;
#(
    parameter int W = lc4_md_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gwe,
    input  logic         i_valid,
    input  logic         i_flush,
    input  logic [15:0]  i_insn,
    input  logic [W-1:0] i_r1data,
    input  logic [W-1:0] i_r2data,
    output logic         o_stall,
    output logic         o_done,
    output logic [W-1:0] o_result
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t        state, state_next;
    op_t           op_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc, rem, opa, opb;
    logic [W-1:0]  acc_next, rem_next;

    md_dec_t dec;
    logic    accept;
    logic    load;
    logic    step_en;
    logic    finish;

    assign dec    = decode_md(i_insn);
    assign accept = i_valid & dec.is_md & ~i_flush;

    lc4_md_step #(.W(W)) u_step (
        .op       (op_q),
        .acc      (acc),
        .rem      (rem),
        .opa      (opa),
        .opb      (opb),
        .acc_next (acc_next),
        .rem_next (rem_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (gwe) begin
            state <= state_next;
        end
    end

    // Next state, datapath controls and stall.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
        o_stall    = 1'b0;
        unique case (state)
            IDLE: begin
                o_stall = accept;
                if (gwe && accept) begin
                    load = 1'b1;
                    // A zero divisor has a known result of 0; skip iterating.
                    if (dec.op != MUL && i_r2data == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                o_stall = 1'b1;
                if (gwe) begin
                    if (i_flush) begin
                        state_next = IDLE;
                    end else begin
                        step_en = 1'b1;
                        if (cnt == CNT_LAST) begin
                            finish     = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                // The finished instruction is still in X this cycle, so i_valid
                // is ignored here; flush and completion both lead to IDLE.
                if (gwe) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= MUL;
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            opa      <= '0;
            opb      <= '0;
            o_done   <= 1'b0;
            o_result <= '0;
        end else if (gwe) begin
            o_done <= (state_next == DONE);
            if (load) begin
                op_q <= dec.op;
                opa  <= i_r1data;
                opb  <= i_r2data;
                acc  <= '0;
                rem  <= '0;
                cnt  <= '0;
                if (state_next == DONE) begin
                    o_result <= '0;
                end
            end else if (step_en) begin
                acc <= acc_next;
                rem <= rem_next;
                opa <= opa << 1;
                if (op_q == MUL) begin
                    opb <= opb >> 1;
                end
                if (finish) begin
                    o_result <= (op_q == MOD) ? rem_next : acc_next;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
